// File: rtl/prog_clock_divider.sv
// Programmable multi-channel tick/square divider plus legacy free-running count.
// Define CLKDIV_SYNC_EN to add a `sync` input that phase-aligns every channel.
module prog_clock_divider #(
  parameter int          CHANNELS    = 4,
  parameter int          WIDTH       = 26,
  parameter int          FREE_WIDTH  = 32,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        load,
  input  logic [$clog2(CHANNELS)-1:0] load_ch,
  input  logic [WIDTH-1:0]            load_div,
`ifdef CLKDIV_SYNC_EN
  input  logic                        sync,
`endif
  output logic [FREE_WIDTH-1:0]       free_count,
  output logic [CHANNELS-1:0]         tick,
  output logic [CHANNELS-1:0]         square
);

  localparam int               CW      = $clog2(CHANNELS);
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]    cnt [CHANNELS];
  logic [WIDTH-1:0]    div [CHANNELS];
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] term;

  // Terminal test uses cnt+1 so div-1 is never formed; cnt+1 cannot wrap
  // because cnt never exceeds div-1.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i]  = load && (load_ch == CW'(i));
      term[i] = (div[i] != '0) && ((cnt[i] + WIDTH'(1)) == div[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_count <= '0;
      tick       <= '0;
      square     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        div[i] <= DIV_RST;
      end
    end else begin
      free_count <= free_count + FREE_WIDTH'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        if (hit[i]) begin
          div[i]  <= load_div;
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
`ifdef CLKDIV_SYNC_EN
          if (sync) square[i] <= 1'b0;
        end else if (sync) begin
          cnt[i]    <= '0;
          tick[i]   <= 1'b0;
          square[i] <= 1'b0;
`endif
        end else if (enable && (div[i] != '0)) begin
          if (term[i]) begin
            cnt[i]    <= '0;
            tick[i]   <= 1'b1;
            square[i] <= ~square[i];
          end else begin
            cnt[i]  <= cnt[i] + WIDTH'(1);
            tick[i] <= 1'b0;
          end
        end else begin
          // Disabled or switched-off channel: hold count and square.
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Randomised bench for prog_clock_divider against an elapsed-cycle modulo model.
// Five channels so that load_ch values 5..7 exercise the ignored-index path.
module tb_prog_clock_divider;
  localparam int CH = 5;
  localparam int W  = 26;
  localparam int FW = 32;
  localparam int CW = $clog2(CH);

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          load;
  logic [CW-1:0] load_ch;
  logic [W-1:0]  load_div;
  logic          sync_s;
  logic [FW-1:0] free_count;
  logic [CH-1:0] tick;
  logic [CH-1:0] square;

  prog_clock_divider #(.CHANNELS(CH), .WIDTH(W), .FREE_WIDTH(FW), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_ch(load_ch),
    .load_div(load_div),
`ifdef CLKDIV_SYNC_EN
    .sync(sync_s),
`endif
    .free_count(free_count), .tick(tick), .square(square)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each channel counts enabled edges since its last load/reset/sync;
  // a tick falls whenever that count is a multiple of the divisor.
  int            m_div [CH];
  int            m_ec  [CH];
  logic [CH-1:0] m_tick;
  logic [CH-1:0] m_sq;
  logic [FW-1:0] m_free;

  task automatic model_reset();
    m_free = '0; m_tick = '0; m_sq = '0;
    for (int i = 0; i < CH; i++) begin m_div[i] = 4; m_ec[i] = 0; end
  endtask

  task automatic step(input logic en, input logic ld, input int ch, input int dv, input logic sy);
    enable = en; load = ld; load_ch = CW'(ch); load_div = W'(dv); sync_s = sy;
    @(posedge clk);
    m_free = m_free + 1;
    for (int i = 0; i < CH; i++) begin
      if (ld && ch == i) begin
        m_div[i] = dv; m_ec[i] = 0; m_tick[i] = 1'b0;
        if (sy) m_sq[i] = 1'b0;
      end else if (sy) begin
        m_ec[i] = 0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
      end else if (en && m_div[i] != 0) begin
        m_ec[i]++;
        m_tick[i] = (m_ec[i] % m_div[i] == 0);
        if (m_tick[i]) m_sq[i] = ~m_sq[i];
      end else begin
        m_tick[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; load = 1'b0; load_ch = '0; load_div = '0; sync_s = 1'b0;
    #12;
    n_checks++;
    if ({free_count, tick, square} !== '0)
      $display("FAIL reset_state: got fc=%0d tick=%b sq=%b, want all 0", free_count, tick, square);
    else n_pass++;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_defaults();
    for (int e = 1; e <= 12; e++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (tick !== ((e % 4 == 0) ? {CH{1'b1}} : {CH{1'b0}}) || free_count !== FW'(e) ||
          square !== ((e >= 4 && e < 8) || e >= 12 ? {CH{1'b1}} : {CH{1'b0}}))
        $display("FAIL defaults edge %0d: tick=%b sq=%b fc=%0d", e, tick, square, free_count);
      else n_pass++;
    end
  endtask

  task automatic test_div_one();
    step(1'b1, 1'b1, 2, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step(1'b1, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (tick[2] !== (k > 0) || {free_count, tick, square} !== {m_free, m_tick, m_sq})
        $display("FAIL div_one k=%0d: tick=%b sq=%b fc=%0d, want tick=%b sq=%b fc=%0d",
                 k, tick, square, free_count, m_tick, m_sq, m_free);
      else n_pass++;
    end
  endtask

  task automatic test_off();
    logic sq1;
    step(1'b1, 1'b1, 1, 0, 1'b0);
    sq1 = square[1];
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (tick[1] !== 1'b0 || square[1] !== sq1 || {tick, square} !== {m_tick, m_sq})
        $display("FAIL off k=%0d: tick=%b sq=%b, want tick=%b sq=%b", k, tick, square, m_tick, m_sq);
      else n_pass++;
    end
    step(1'b1, 1'b1, 1, 3, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (tick[1] !== (k % 3 == 0) || {tick, square} !== {m_tick, m_sq})
        $display("FAIL div3 k=%0d: tick=%b, want tick[1]=%0d model=%b", k, tick, (k % 3 == 0), m_tick);
      else n_pass++;
    end
  endtask

  task automatic test_load_terminal();
    step(1'b1, 1'b1, 0, 4, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 0, 5, 1'b0);
    n_checks++;
    if (tick[0] !== 1'b0) $display("FAIL load_beats_tc: tick[0]=%b want 0", tick[0]);
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (tick[0] !== (k == 5) || {tick, square} !== {m_tick, m_sq})
        $display("FAIL div5 k=%0d: tick=%b, want tick[0]=%0d model=%b", k, tick, (k == 5), m_tick);
      else n_pass++;
    end
    step(1'b1, 1'b1, 7, 9, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if ({free_count, tick, square} !== {m_free, m_tick, m_sq})
        $display("FAIL bad_ch k=%0d: tick=%b sq=%b, want tick=%b sq=%b", k, tick, square, m_tick, m_sq);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    logic [FW-1:0] fc0;
    step(1'b1, 1'b1, 0, 4, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    fc0 = free_count;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (tick !== '0) $display("FAIL enable_low k=%0d: tick=%b want 0", k, tick);
      else n_pass++;
    end
    n_checks++;
    if (free_count !== fc0 + 10) $display("FAIL enable_fc: got %0d want %0d", free_count, fc0 + 10);
    else n_pass++;
    for (int k = 1; k <= 2; k++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (tick[0] !== (k == 2) || {tick, square} !== {m_tick, m_sq})
        $display("FAIL resume k=%0d: tick=%b want tick[0]=%0d model=%b", k, tick, (k == 2), m_tick);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0);
      n_checks++;
      if ({free_count, tick, square} !== {m_free, m_tick, m_sq})
        $display("FAIL random k=%0d: fc=%0d tick=%b sq=%b, want fc=%0d tick=%b sq=%b",
                 k, free_count, tick, square, m_free, m_tick, m_sq);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 0, 7, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({free_count, tick, square} !== '0)
      $display("FAIL async_reset: fc=%0d tick=%b sq=%b want 0", free_count, tick, square);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({free_count, tick, square} !== '0)
      $display("FAIL reset_hold: fc=%0d tick=%b sq=%b want 0", free_count, tick, square);
    else n_pass++;
    reset = 1'b1;
    model_reset();
    for (int e = 1; e <= 4; e++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (tick !== ((e == 4) ? {CH{1'b1}} : {CH{1'b0}}) || {free_count, square} !== {m_free, m_sq})
        $display("FAIL post_reset e=%0d: tick=%b sq=%b fc=%0d", e, tick, square, free_count);
      else n_pass++;
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    step(1'b1, 1'b1, 0, 4, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 3, 4, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (tick !== ((e % 4 == 0) ? {CH{1'b1}} : {CH{1'b0}}) || {free_count, square} !== {m_free, m_sq})
        $display("FAIL sync e=%0d: tick=%b sq=%b fc=%0d", e, tick, square, free_count);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_defaults();
    test_div_one();
    test_off();
    test_load_terminal();
    test_enable();
    test_random();
    test_async_reset();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
